// File: rtl/led_pkg.sv
// Shared register map and mode encoding for the LED controller.
package led_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 2'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_ROTATE = 2'd3
    } mode_e;

endpackage

// File: rtl/led_tick_gen.sv
// Programmable timebase: one-cycle tick every period+1 clocks, restartable by clear.
module led_tick_gen #(
    parameter int unsigned PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  clear,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    // Clear wins over the terminal count so a restart never emits a tick.
    assign tick = !clear && (cnt == period);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: static, blink, PWM-dim and rotate modes.
module led_ctrl
    import led_pkg::*;
#(
    parameter int unsigned             NUM_LEDS   = 8,
    parameter int unsigned             PWM_BITS   = 4,
    parameter int unsigned             PRESCALE_W = 24,
    parameter logic [PRESCALE_W-1:0]   PERIOD_RST = PRESCALE_W'(12_500_000)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [BUS_W-1:0]    wr_data,
    output logic [BUS_W-1:0]    rd_data,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [NUM_LEDS-1:0]   data;
    logic [NUM_LEDS-1:0]   data_rot;
    logic [NUM_LEDS-1:0]   led_nxt;
    mode_e                 mode;
    logic [PWM_BITS-1:0]   duty;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PRESCALE_W-1:0] period;
    logic                  phase;
    logic                  pwm_on;
    logic                  tick;
    logic                  tb_clear;
    logic                  unused_wr;

    assign unused_wr = ^wr_data;

    // MODE/PERIOD writes restart the timebase and blink phase.
    assign tb_clear = wr_en && ((addr == ADDR_MODE) || (addr == ADDR_PERIOD));
    assign pwm_on   = (pwm_cnt < duty);

    generate
        if (NUM_LEDS > 1) begin : g_rot
            assign data_rot = {data[NUM_LEDS-2:0], data[NUM_LEDS-1]};
        end else begin : g_norot
            assign data_rot = data;
        end
    endgenerate

    led_tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .period (period),
        .clear  (tb_clear),
        .tick   (tick)
    );

    always_comb begin
        led_nxt = '0;
        case (mode)
            MODE_STATIC: led_nxt = data;
            MODE_BLINK:  led_nxt = phase ? data : '0;
            MODE_PWM:    led_nxt = data & {NUM_LEDS{pwm_on}};
            MODE_ROTATE: led_nxt = data;
            default:     led_nxt = '0;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA:   rd_data = BUS_W'(data);
            ADDR_MODE:   rd_data = BUS_W'(mode);
            ADDR_DUTY:   rd_data = BUS_W'(duty);
            ADDR_PERIOD: rd_data = BUS_W'(period);
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            mode    <= MODE_STATIC;
            duty    <= '1;
            period  <= PERIOD_RST;
            pwm_cnt <= '0;
            phase   <= 1'b0;
            led_out <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_MAX) ? '0 : pwm_cnt + PWM_BITS'(1);

            if (tb_clear) begin
                phase <= 1'b0;
            end else if (tick) begin
                phase <= ~phase;
            end

            // A bus write to DATA takes priority over a concurrent rotation.
            if (wr_en && (addr == ADDR_DATA)) begin
                data <= wr_data[NUM_LEDS-1:0];
            end else if (tick && (mode == MODE_ROTATE)) begin
                data <= data_rot;
            end

            if (wr_en) begin
                case (addr)
                    ADDR_MODE:   mode   <= mode_e'(wr_data[1:0]);
                    ADDR_DUTY:   duty   <= wr_data[PWM_BITS-1:0];
                    ADDR_PERIOD: period <= wr_data[PRESCALE_W-1:0];
                    default:     ;
                endcase
            end

            led_out <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed self-checking bench for led_ctrl with default parameters.
module tb_led_ctrl;
    import led_pkg::*;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  led_out;

    int n_cmp;
    int n_bad;

    led_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus write; returns 1 time unit after the capturing edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_led: got %h want %h", led_out, 8'h00);
        end
        addr = ADDR_DATA; #1;
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want %h", rd_data, 32'h0);
        end
        addr = ADDR_MODE; #1;
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mode: got %h want %h", rd_data, 32'h0);
        end
        addr = ADDR_DUTY; #1;
        n_cmp++;
        if (rd_data !== 32'hF) begin
            n_bad++;
            $display("FAIL reset_duty: got %h want %h", rd_data, 32'hF);
        end
        addr = ADDR_PERIOD; #1;
        n_cmp++;
        if (rd_data !== 32'h00BE_BC20) begin
            n_bad++;
            $display("FAIL reset_period: got %h want %h", rd_data, 32'h00BE_BC20);
        end
    endtask

    task automatic test_static();
        bus_write(ADDR_DATA, 32'h0000_00A5);
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL static_latency: got %h want %h", led_out, 8'h00);
        end
        n_cmp++;
        if (rd_data !== 32'h0000_00A5) begin
            n_bad++;
            $display("FAIL static_readback: got %h want %h", rd_data, 32'h0000_00A5);
        end
        step();
        n_cmp++;
        if (led_out !== 8'hA5) begin
            n_bad++;
            $display("FAIL static_led: got %h want %h", led_out, 8'hA5);
        end
        bus_write(ADDR_DATA, 32'hFFFF_FF5A);
        n_cmp++;
        if (rd_data !== 32'h0000_005A) begin
            n_bad++;
            $display("FAIL data_upper_bits: got %h want %h", rd_data, 32'h0000_005A);
        end
        step();
        n_cmp++;
        if (led_out !== 8'h5A) begin
            n_bad++;
            $display("FAIL static_led2: got %h want %h", led_out, 8'h5A);
        end
    endtask

    task automatic test_blink();
        logic [7:0] exp;
        bus_write(ADDR_PERIOD, 32'd3);
        bus_write(ADDR_DATA, 32'hFF);
        bus_write(ADDR_MODE, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = ((((k - 1) / 4) % 2) == 1) ? 8'hFF : 8'h00;
            n_cmp++;
            if (led_out !== exp) begin
                n_bad++;
                $display("FAIL blink_cycle%0d: got %h want %h", k, led_out, exp);
            end
        end
    endtask

    task automatic test_pwm();
        int on_cnt;
        int other;
        bus_write(ADDR_DUTY, 32'd5);
        bus_write(ADDR_DATA, 32'h0F);
        bus_write(ADDR_MODE, 32'd2);
        step();
        on_cnt = 0;
        other  = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (led_out === 8'h0F) on_cnt++;
            else if (led_out !== 8'h00) other++;
        end
        n_cmp++;
        if (on_cnt !== 5 || other !== 0) begin
            n_bad++;
            $display("FAIL pwm_duty5: on=%0d stray=%0d want on=5 stray=0", on_cnt, other);
        end

        bus_write(ADDR_DUTY, 32'd0);
        other = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (led_out !== 8'h00) other++;
        end
        n_cmp++;
        if (other !== 0) begin
            n_bad++;
            $display("FAIL pwm_duty0: %0d cycles not 00, want 0", other);
        end

        bus_write(ADDR_DUTY, 32'd15);
        other = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (led_out !== 8'h0F) other++;
        end
        n_cmp++;
        if (other !== 0) begin
            n_bad++;
            $display("FAIL pwm_duty15: %0d cycles not 0F, want 0", other);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h81;
        exp_seq[1] = 8'h03;
        exp_seq[2] = 8'h06;
        exp_seq[3] = 8'h0C;
        bus_write(ADDR_MODE, 32'd3);
        bus_write(ADDR_PERIOD, 32'd0);
        bus_write(ADDR_DATA, 32'h81);
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (led_out !== exp_seq[k]) begin
                n_bad++;
                $display("FAIL rotate_step%0d: got %h want %h", k, led_out, exp_seq[k]);
            end
        end
        // DATA write lands on a tick cycle: the written value is kept unrotated.
        bus_write(ADDR_DATA, 32'h01);
        n_cmp++;
        if (rd_data !== 32'h01) begin
            n_bad++;
            $display("FAIL rotate_collide_rd: got %h want %h", rd_data, 32'h01);
        end
        step();
        n_cmp++;
        if (led_out !== 8'h01) begin
            n_bad++;
            $display("FAIL rotate_collide_led: got %h want %h", led_out, 8'h01);
        end
        step();
        n_cmp++;
        if (led_out !== 8'h02) begin
            n_bad++;
            $display("FAIL rotate_after_collide: got %h want %h", led_out, 8'h02);
        end
        // DUTY write on a tick cycle must not stop the rotation.
        bus_write(ADDR_DUTY, 32'd3);
        step();
        n_cmp++;
        if (led_out !== 8'h08) begin
            n_bad++;
            $display("FAIL rotate_duty_write: got %h want %h", led_out, 8'h08);
        end
    endtask

    task automatic test_reset_mid();
        bus_write(ADDR_PERIOD, 32'd2);
        bus_write(ADDR_DATA, 32'hFF);
        bus_write(ADDR_MODE, 32'd1);
        for (int k = 0; k < 5; k++) step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_led: got %h want %h", led_out, 8'h00);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        addr = ADDR_MODE; #1;
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_mode: got %h want %h", rd_data, 32'h0);
        end
        addr = ADDR_PERIOD; #1;
        n_cmp++;
        if (rd_data !== 32'h00BE_BC20) begin
            n_bad++;
            $display("FAIL reset_mid_period: got %h want %h", rd_data, 32'h00BE_BC20);
        end
        addr = ADDR_DUTY; #1;
        n_cmp++;
        if (rd_data !== 32'hF) begin
            n_bad++;
            $display("FAIL reset_mid_duty: got %h want %h", rd_data, 32'hF);
        end
        step();
        n_cmp++;
        if (led_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_led_after: got %h want %h", led_out, 8'h00);
        end
    endtask

    task automatic test_mode_wide();
        bus_write(ADDR_PERIOD, 32'd0);
        bus_write(ADDR_DATA, 32'h81);
        bus_write(ADDR_MODE, 32'hFFFF_FFFF);
        n_cmp++;
        if (rd_data !== 32'h3) begin
            n_bad++;
            $display("FAIL mode_wide_rd: got %h want %h", rd_data, 32'h3);
        end
        step();
        n_cmp++;
        if (led_out !== 8'h81) begin
            n_bad++;
            $display("FAIL mode_wide_led0: got %h want %h", led_out, 8'h81);
        end
        step();
        n_cmp++;
        if (led_out !== 8'h03) begin
            n_bad++;
            $display("FAIL mode_wide_led1: got %h want %h", led_out, 8'h03);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        addr    = 2'd0;
        wr_data = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_static();
        test_blink();
        test_pwm();
        test_rotate();
        test_reset_mid();
        test_mode_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
Memory-mapped, parametrised LED controller for the CPU peripheral bus. It is the successor to the plain 8-bit LED latch.
- Generic LED count.
- Four output modes: static, blink, PWM dim, rotate.
- Programmable timebase.
- Register readback.
Sits on the peripheral bus next to the other I/O blocks and drives the board LED pins.

Parameters:
NUM_LEDS, 8, number of LED outputs (1..32)
PWM_BITS, 4, duty resolution; PWM frame = 2^PWM_BITS-1 clk cycles
PRESCALE_W, 24, width of timebase prescaler / PERIOD register
PERIOD_RST, 24'd12_500_000, PERIOD reset value (blink/rotate tick interval in clk cycles, minus 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  bus write strobe, sampled on posedge clk
addr  in  2  register select: 0 DATA, 1 MODE, 2 DUTY, 3 PERIOD
wr_data  in  32  write data; only low field bits used
rd_data  out  32  combinational readback of addressed register, zero-extended
led_out  out  NUM_LEDS  registered LED drive, 1 = on

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-high.
  - DATA=0, MODE=0, DUTY=all ones, PERIOD=PERIOD_RST.
  - Prescaler=0, pwm_cnt=0, blink phase=0, led_out=0.
- Registers:
  - DATA[NUM_LEDS-1:0]
  - MODE[1:0]: 0 STATIC, 1 BLINK, 2 PWM, 3 ROTATE
  - DUTY[PWM_BITS-1:0]
  - PERIOD[PRESCALE_W-1:0]
  - Writes take effect at the clk edge where wr_en=1.
- Tick:
  - Prescaler counts 0..PERIOD; tick=1 for one cycle when prescaler==PERIOD, then the prescaler wraps to 0.
  - PERIOD=0 gives a tick every cycle.
  - A write to PERIOD or MODE clears the prescaler and blink phase that cycle; no tick is issued in that cycle.
- PWM counter: free-runs 0..2^PWM_BITS-2 and wraps; pwm_on = (pwm_cnt < DUTY).
  - DUTY=0 means always off.
  - DUTY=all ones means always on.
- Output, next-cycle value of led_out:
  - STATIC: DATA
  - BLINK: DATA when phase=1, else 0; phase toggles on each tick
  - PWM: DATA & {NUM_LEDS{pwm_on}}
  - ROTATE: DATA; on each tick DATA rotates left by 1 (MSB->LSB) and readback shows the rotated value
- Latency: one clk from register/state change to led_out.
- Simultaneous events:
  - DATA write and rotate tick in the same cycle: the write wins and the rotation is dropped.
  - A write to a non-DATA register in a tick cycle does not block the rotation, except for MODE/PERIOD writes, which suppress the tick as above.
- Width rules: upper wr_data bits are ignored, and rd_data upper bits read 0. NUM_LEDS=1 makes rotate a no-op.
- Reset mid-operation: all state returns immediately (async) to the reset values; the first tick follows PERIOD+1 cycles after release.

Decomposition:
- Shared package led_pkg:
  - Address constants ADDR_DATA/MODE/DUTY/PERIOD
  - Mode enum/localparams MODE_STATIC/BLINK/PWM/ROTATE
- One sub-module, led_tick_gen:
  - Inputs: clk, reset, period, clear.
  - Output: tick.
  - Parametrised by PRESCALE_W; reusable for other timed peripherals.

Test Plan:
- Reset, then write DATA=0xA5 (MODE 0) -> led_out=0xA5 one cycle after write; rd_data at addr 0 = 0x000000A5.
- PERIOD=3, MODE=1, DATA=0xFF -> led_out alternates 0xFF/0x00 every 4 cycles, starting 0x00 for the first 4 cycles after the MODE write.
- MODE=2, DATA=0x0F, DUTY=5, PWM_BITS=4 -> led_out=0x0F for 5 of every 15 cycles. DUTY=0 -> constant 0x00. DUTY=15 -> constant 0x0F.
- MODE=3, PERIOD=0, DATA=0x81 -> successive led_out 0x81, 0x03, 0x06, 0x0C. A DATA write of 0x01 on a tick cycle yields 0x01, not rotated.
- MODE=1 running, PERIOD=2; assert reset for 2 cycles mid-blink -> led_out=0, MODE reads 0, PERIOD reads PERIOD_RST, DUTY reads all ones.
- wr_data=0xFFFFFFFF to MODE -> MODE reads 3; led_out follows rotate mode; rd_data[31:2]=0.
